// File: rtl/mcu_encode_scheduler_pkg.sv
// Shared types and constants for the MCU encode scheduler, component encoders and bit packer.
package mcu_encode_scheduler_pkg;

  localparam int DCT_TH     = 28;
  localparam int PIPE_LAT   = 5;
  localparam int ADDR_SETUP = 2;
  localparam int XW         = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_BURST = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic  active;
    comp_e comp;
  } tag_t;

  function automatic comp_e next_comp(input comp_e c);
    case (c)
      COMP_Y:  return COMP_CB;
      COMP_CB: return COMP_CR;
      default: return COMP_Y;
    endcase
  endfunction

endpackage

// File: rtl/mcu_encode_scheduler_if.sv
// Scheduler <-> component encoder bundle: shared read address, burst requests, code returns.
interface mcu_encode_scheduler_if #(
  parameter int XW = 8
);
  logic [XW-1:0] e_x_mcu;
  logic          ereq_y;
  logic          ereq_cb;
  logic          ereq_cr;
  logic [5:0]    elen_y;
  logic [5:0]    elen_cb;
  logic [5:0]    elen_cr;
  logic [31:0]   edata_y;
  logic [31:0]   edata_cb;
  logic [31:0]   edata_cr;

  modport master (
    output e_x_mcu, ereq_y, ereq_cb, ereq_cr,
    input  elen_y, elen_cb, elen_cr, edata_y, edata_cb, edata_cr
  );

  modport slave (
    input  e_x_mcu, ereq_y, ereq_cb, ereq_cr,
    output elen_y, elen_cb, elen_cr, edata_y, edata_cb, edata_cr
  );
endinterface

// File: rtl/mcu_encode_scheduler_tag_pipe.sv
// encode_tag_pipe: DEPTH-deep {active, comp} delay line aligning burst tags with encoder output.
module mcu_encode_scheduler_tag_pipe
  import mcu_encode_scheduler_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] pipe_q;

  // Flush also drops the tag entering this cycle so nothing issued before it survives.
  always_ff @(posedge clk) begin
    if (rst || flush_i) pipe_q <= '0;
    else                pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mcu_encode_scheduler.sv
// Sequences Y/Cb/Cr encoder bursts per MCU row, owns the capture page, merges codes to the packer.
module mcu_encode_scheduler
  import mcu_encode_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_done_i,
  input  logic [XW-1:0]         h_mcu_i,
  input  logic                  vsync_i,
  input  logic                  out_space_i,
  output logic                  page_o,
  output logic                  code_valid_o,
  output logic [5:0]            code_len_o,
  output logic [31:0]           code_data_o,
  output logic                  row_encoded_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  mcu_encode_scheduler_if.master enc
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  comp_e              comp_q, comp_d;
  logic [XW-1:0]      x_q, x_d, h_q, h_d, x_inc;
  logic               page_q, page_d, ovr_q, ovr_d;
  logic               flush, row_enc, busy;
  tag_t               tag_in, tag_out;
  logic [5:0]         sel_len;
  logic [31:0]        sel_data;

  assign busy  = (state_q != S_IDLE);
  assign x_inc = x_q + XW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      comp_q  <= COMP_Y;
      x_q     <= '0;
      h_q     <= XW'(1);
      page_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
      x_q     <= x_d;
      h_q     <= h_d;
      page_q  <= page_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    comp_d  = comp_q;
    x_d     = x_q;
    h_d     = h_q;
    page_d  = page_q;
    ovr_d   = ovr_q;
    flush   = 1'b0;
    row_enc = 1'b0;

    if (busy && (row_done_i || vsync_i)) ovr_d = 1'b1;

    // A frame boundary mid-row abandons the row; in-flight codes are discarded.
    if (busy && vsync_i) begin
      flush   = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (row_done_i) begin
            page_d  = ~page_q;
            h_d     = (h_mcu_i == '0) ? XW'(1) : h_mcu_i;
            x_d     = '0;
            comp_d  = COMP_Y;
            cnt_d   = '0;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q < CNT_W'(ADDR_SETUP - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (out_space_i) begin
            cnt_d   = '0;
            state_d = S_BURST;
          end
        end
        S_BURST: begin
          if (cnt_q == CNT_W'(DCT_TH)) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          cnt_d   = '0;
          comp_d  = next_comp(comp_q);
          state_d = S_SETUP;
          if (comp_q == COMP_CR) begin
            x_d = x_inc;
            if (x_inc == h_q) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
            row_enc = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign enc.e_x_mcu = x_q;
  assign enc.ereq_y  = (state_q == S_BURST) && (comp_q == COMP_Y);
  assign enc.ereq_cb = (state_q == S_BURST) && (comp_q == COMP_CB);
  assign enc.ereq_cr = (state_q == S_BURST) && (comp_q == COMP_CR);

  always_comb begin
    tag_in        = '0;
    tag_in.active = (state_q == S_BURST);
    tag_in.comp   = comp_q;
  end

  mcu_encode_scheduler_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  always_comb begin
    sel_len  = '0;
    sel_data = '0;
    case (tag_out.comp)
      COMP_Y:  begin sel_len = enc.elen_y;  sel_data = enc.edata_y;  end
      COMP_CB: begin sel_len = enc.elen_cb; sel_data = enc.edata_cb; end
      COMP_CR: begin sel_len = enc.elen_cr; sel_data = enc.edata_cr; end
      default: ;
    endcase
    code_valid_o = tag_out.active && (sel_len != '0);
    code_len_o   = code_valid_o ? sel_len  : '0;
    code_data_o  = code_valid_o ? sel_data : '0;
  end

  assign page_o        = page_q;
  assign row_encoded_o = row_enc;
  assign busy_o        = busy;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_mcu_encode_scheduler.sv
// Scoreboard bench: directed rows push expected bursts/codes/row_encoded; monitors pop and compare.
module tb_mcu_encode_scheduler;
  import mcu_encode_scheduler_pkg::*;

  logic          clk = 1'b0, rst = 1'b1;
  logic          row_done = 1'b0, vsync = 1'b0, out_space = 1'b1;
  logic [XW-1:0] h_mcu = '0;
  logic          page, code_valid, row_encoded, busy, overrun;
  logic [5:0]    code_len;
  logic [31:0]   code_data;

  mcu_encode_scheduler_if #(.XW(XW)) eif();

  mcu_encode_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .row_done_i    (row_done),
    .h_mcu_i       (h_mcu),
    .vsync_i       (vsync),
    .out_space_i   (out_space),
    .page_o        (page),
    .code_valid_o  (code_valid),
    .code_len_o    (code_len),
    .code_data_o   (code_data),
    .row_encoded_o (row_encoded),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .enc           (eif.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Encoder stub: answers each ereq cycle PIPE_LAT cycles later, garbage otherwise.
  int stub_mode = 0;

  function automatic logic [5:0] stub_len(input int mode, input int st);
    if (mode == 0) return 6'd3;
    case (st % 5)
      0:       return 6'd0;
      1:       return 6'd1;
      2:       return 6'd7;
      3:       return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] stub_data(input int c, input int st);
    return {8'(c + 1), 24'(st)};
  endfunction

  logic [2:0] sreq [PIPE_LAT] = '{default: '0};
  int         sst  [PIPE_LAT] = '{default: 0};

  always @(posedge clk) begin
    sreq[0] <= {eif.ereq_cr, eif.ereq_cb, eif.ereq_y};
    sst[0]  <= cyc;
    for (int i = 1; i < PIPE_LAT; i++) begin
      sreq[i] <= sreq[i-1];
      sst[i]  <= sst[i-1];
    end
  end

  always_comb begin
    eif.elen_y  = 6'd9;  eif.edata_y  = 32'hDEAD_BEEF;
    eif.elen_cb = 6'd9;  eif.edata_cb = 32'hDEAD_BEEF;
    eif.elen_cr = 6'd9;  eif.edata_cr = 32'hDEAD_BEEF;
    if (sreq[PIPE_LAT-1][0]) begin
      eif.elen_y  = stub_len(stub_mode, sst[PIPE_LAT-1]);
      eif.edata_y = stub_data(0, sst[PIPE_LAT-1]);
    end
    if (sreq[PIPE_LAT-1][1]) begin
      eif.elen_cb  = stub_len(stub_mode, sst[PIPE_LAT-1]);
      eif.edata_cb = stub_data(1, sst[PIPE_LAT-1]);
    end
    if (sreq[PIPE_LAT-1][2]) begin
      eif.elen_cr  = stub_len(stub_mode, sst[PIPE_LAT-1]);
      eif.edata_cr = stub_data(2, sst[PIPE_LAT-1]);
    end
  end

  typedef struct { int at; logic [5:0] len; logic [31:0] data; } code_t;
  typedef struct { int comp; int start; int x; int len; } burst_t;
  code_t  code_q [$];
  burst_t burst_q[$];
  int     re_q   [$];

  task automatic push_burst(input int c, input int s, input int x, input int len, input int upto);
    int st;
    logic [5:0] l;
    burst_q.push_back('{c, s, x, len});
    for (int k = 0; k < len; k++) begin
      st = s + k;
      l  = stub_len(stub_mode, st);
      if (st <= upto && l != 6'd0) code_q.push_back('{st + PIPE_LAT, l, stub_data(c, st)});
    end
  endtask

  task automatic push_mcu(input int base, input int x);
    for (int c = 0; c < 3; c++) push_burst(c, base + 32 * c, x, DCT_TH + 1, 1 << 30);
  endtask

  task automatic drained(input string nm);
    check({nm, "_codes_left"}, code_q.size(), 0);
    check({nm, "_bursts_left"}, burst_q.size(), 0);
    check({nm, "_row_encoded_left"}, re_q.size(), 0);
  endtask

  task automatic go(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Code / row_encoded monitor.
  int zero_err = 0, n_codes = 0;
  initial forever begin
    code_t e;
    @(negedge clk);
    if (!rst) begin
      if (code_valid) begin
        n_codes++;
        if (code_q.size() == 0) check("unexpected_code", code_valid, 0);
        else begin
          e = code_q.pop_front();
          check("code_cycle", cyc, e.at);
          check("code_len", code_len, e.len);
          check("code_data", code_data, e.data);
        end
      end else if (code_len != 6'd0 || code_data != 32'd0) zero_err++;
      if (row_encoded) begin
        if (re_q.size() == 0) check("unexpected_row_encoded", row_encoded, 0);
        else check("row_encoded_cycle", cyc, re_q.pop_front());
      end
    end
  end

  // Burst monitor: shape, address stability and gap between bursts.
  initial begin
    logic [2:0]    v, pv;
    logic [XW-1:0] px, bx;
    int            x_chg, b_start, b_comp;
    bit            b_bad;
    burst_t        e;
    pv = '0; px = '0; bx = '0; x_chg = -100; b_start = 0; b_comp = 0; b_bad = 0;
    forever begin
      @(negedge clk);
      v = {eif.ereq_cr, eif.ereq_cb, eif.ereq_y};
      if (eif.e_x_mcu != px) x_chg = cyc;
      if (v != 3'b0 && pv == 3'b0) begin
        b_start = cyc;
        b_comp  = v[2] ? 2 : (v[1] ? 1 : 0);
        bx      = eif.e_x_mcu;
        b_bad   = ($countones(v) != 1) || (cyc - x_chg < ADDR_SETUP);
      end else if (v != 3'b0 && (v != pv || eif.e_x_mcu != px)) b_bad = 1'b1;
      if (v == 3'b0 && pv != 3'b0) begin
        if (burst_q.size() == 0) check("unexpected_burst", pv, 0);
        else begin
          e = burst_q.pop_front();
          check("burst_comp", b_comp, e.comp);
          check("burst_start", b_start, e.start);
          check("burst_x", bx, e.x);
          check("burst_len", cyc - b_start, e.len);
          check("burst_shape", b_bad, 0);
        end
      end
      pv = v;
      px = eif.e_x_mcu;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int R, V;
    go(3); rst = 1'b0;
    go(5);
    check("rst_page", page, 0);
    check("rst_x", eif.e_x_mcu, 0);
    check("rst_ereq", {eif.ereq_cr, eif.ereq_cb, eif.ereq_y}, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_code_len", code_len, 0);
    check("rst_code_data", code_data, 0);
    check("rst_row_encoded", row_encoded, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // One MCU, constant elen=3.
    R = 10; stub_mode = 0; h_mcu = 8'd1; n_codes = 0;
    push_mcu(R + 3, 0);
    re_q.push_back(R + 101);
    go(R); row_done = 1'b1;
    go(R + 1); row_done = 1'b0;
    check("a_page", page, 1);
    check("a_busy", busy, 1);
    go(R + 101);
    check("a_busy_drain", busy, 1);
    go(R + 105);
    check("a_code_count", n_codes, 87);
    check("a_busy_end", busy, 0);
    drained("a");

    // h_mcu=0 (treated as 1), out_space low 20 cycles during Cb setup.
    R = 130; stub_mode = 1; h_mcu = 8'd0;
    push_burst(0, R + 3, 0, DCT_TH + 1, 1 << 30);
    push_burst(1, R + 55, 0, DCT_TH + 1, 1 << 30);
    push_burst(2, R + 87, 0, DCT_TH + 1, 1 << 30);
    re_q.push_back(R + 121);
    go(R); row_done = 1'b1;
    go(R + 1); row_done = 1'b0;
    check("c_page", page, 0);
    go(R + 34); out_space = 1'b0;
    go(R + 54); out_space = 1'b1;
    go(R + 125);
    check("c_busy_end", busy, 0);
    check("c_overrun", overrun, 0);
    drained("c");

    // Four MCUs with varied lengths, row_done overrun during the x=2 Y burst.
    R = 270; stub_mode = 1; h_mcu = 8'd4;
    for (int m = 0; m < 4; m++) push_mcu(R + 3 + 96 * m, m);
    re_q.push_back(R + 389);
    go(R); row_done = 1'b1;
    go(R + 1); row_done = 1'b0;
    check("b_page", page, 1);
    go(R + 200); row_done = 1'b1;
    go(R + 201); row_done = 1'b0;
    check("b_overrun", overrun, 1);
    check("b_page_kept", page, 1);
    check("b_busy", busy, 1);
    go(R + 386);
    check("b_busy_drain", busy, 1);
    go(R + 392);
    check("b_busy_end", busy, 0);
    drained("b");

    // Reset during the Cb burst drops everything.
    R = 680; stub_mode = 0; h_mcu = 8'd1;
    push_burst(0, R + 3, 0, DCT_TH + 1, 1 << 30);
    push_burst(1, R + 35, 0, 6, R + 34);
    go(R); row_done = 1'b1;
    go(R + 1); row_done = 1'b0;
    go(R + 40); rst = 1'b1;
    go(R + 41); rst = 1'b0;
    check("e_page", page, 0);
    check("e_x", eif.e_x_mcu, 0);
    check("e_ereq", {eif.ereq_cr, eif.ereq_cb, eif.ereq_y}, 0);
    check("e_code_valid", code_valid, 0);
    check("e_busy", busy, 0);
    check("e_overrun", overrun, 0);
    check("e_row_encoded", row_encoded, 0);
    go(R + 55);
    drained("e");

    // Fresh row after reset, then vsync during the Cr burst.
    R = 740; V = R + 77; stub_mode = 0; h_mcu = 8'd1;
    push_burst(0, R + 3, 0, DCT_TH + 1, 1 << 30);
    push_burst(1, R + 35, 0, DCT_TH + 1, 1 << 30);
    push_burst(2, R + 67, 0, V - (R + 67) + 1, V - PIPE_LAT);
    go(R); row_done = 1'b1;
    go(R + 1); row_done = 1'b0;
    check("d_page", page, 1);
    check("d_overrun_pre", overrun, 0);
    go(V); vsync = 1'b1;
    go(V + 1); vsync = 1'b0;
    check("d_ereq", {eif.ereq_cr, eif.ereq_cb, eif.ereq_y}, 0);
    check("d_busy", busy, 0);
    check("d_overrun", overrun, 1);
    check("d_code_valid", code_valid, 0);
    go(R + 125);
    drained("d");
    check("zero_when_invalid", zero_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
